// File: rtl/dict_loader_if.sv
// Word-wide valid/ready read port used by dict_loader to fetch the packed dictionary image.
interface dict_loader_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] rdata;

    modport master (output valid, output addr, input ready, input rdata);
    modport slave  (input valid, input addr, output ready, output rdata);
endinterface

// File: rtl/dict_loader.sv
// Boot-time loader: streams a packed dictionary image from imem into three dictionary write ports.
// Optional trailing checksum word is enabled with `define DICT_LOADER_CHECKSUM_EN.
module dict_loader #(
    parameter int          FIELD1_VAL_WIDTH = 7,
    parameter int          FIELD2_VAL_WIDTH = 10,
    parameter int          FIELD3_VAL_WIDTH = 15,
    parameter int          FIELD1_KEY_WIDTH = 3,
    parameter int          FIELD2_KEY_WIDTH = 5,
    parameter int          FIELD3_KEY_WIDTH = 8,
    parameter logic [31:0] DICT_BASE        = 32'h000F_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    dict_loader_if.master               mem,
    output logic                        dict1_write_enable,
    output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
    output logic                        dict2_write_enable,
    output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
    output logic                        dict3_write_enable,
    output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
    output logic                        done,
    output logic                        err,
    output logic                        proc_resetn
);

    localparam int N1      = 1 << FIELD1_KEY_WIDTH;
    localparam int N2      = 1 << FIELD2_KEY_WIDTH;
    localparam int N3      = 1 << FIELD3_KEY_WIDTH;
    localparam int N_TOTAL = N1 + N2 + N3;
    localparam int IDX_W   = $clog2(N_TOTAL + 1);

    localparam logic [IDX_W-1:0] LAST1 = IDX_W'(N1 - 1);
    localparam logic [IDX_W-1:0] LAST2 = IDX_W'(N1 + N2 - 1);
    localparam logic [IDX_W-1:0] LAST3 = IDX_W'(N_TOTAL - 1);

    typedef enum logic [3:0] {
        REQ1, WR1, REQ2, WR2, REQ3, WR3, DONE
`ifdef DICT_LOADER_CHECKSUM_EN
        , CHK, ERR
`endif
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0] idx;
    logic [31:0]      addr_q;
    logic             valid_q;
    logic             done_q;
    logic             accept;

    logic valid_d;
    logic we1_d;
    logic we2_d;
    logic we3_d;
    logic done_d;

`ifdef DICT_LOADER_CHECKSUM_EN
    logic [31:0] sum;
    logic        chk_seen;
    logic        chk_ok;
    logic        err_q;
    logic        err_d;
`endif

    assign accept      = valid_q && mem.ready;
    assign mem.valid   = valid_q;
    assign mem.addr    = addr_q;
    assign done        = done_q;
    assign proc_resetn = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= REQ1;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            REQ1: if (accept) state_next = WR1;
            WR1:  state_next = (idx == LAST1) ? REQ2 : REQ1;
            REQ2: if (accept) state_next = WR2;
            WR2:  state_next = (idx == LAST2) ? REQ3 : REQ2;
            REQ3: if (accept) state_next = WR3;
            WR3: begin
                if (idx == LAST3) begin
`ifdef DICT_LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = REQ3;
                end
            end
`ifdef DICT_LOADER_CHECKSUM_EN
            // The checksum word is compared one cycle after it is accepted.
            CHK: if (chk_seen) state_next = chk_ok ? DONE : ERR;
            ERR: state_next = ERR;
`endif
            DONE:    state_next = DONE;
            default: state_next = REQ1;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered without a cycle of lag.
    always_comb begin
        valid_d = 1'b0;
        we1_d   = 1'b0;
        we2_d   = 1'b0;
        we3_d   = 1'b0;
        done_d  = 1'b0;
`ifdef DICT_LOADER_CHECKSUM_EN
        err_d   = 1'b0;
`endif
        unique case (state_next)
            REQ1, REQ2, REQ3: valid_d = 1'b1;
            WR1:              we1_d   = 1'b1;
            WR2:              we2_d   = 1'b1;
            WR3:              we3_d   = 1'b1;
            DONE:             done_d  = 1'b1;
`ifdef DICT_LOADER_CHECKSUM_EN
            CHK:              valid_d = !accept;
            ERR:              err_d   = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q            <= 1'b0;
            dict1_write_enable <= 1'b0;
            dict2_write_enable <= 1'b0;
            dict3_write_enable <= 1'b0;
            done_q             <= 1'b0;
            idx                <= '0;
            addr_q             <= DICT_BASE;
            dict1_write_val    <= '0;
            dict2_write_val    <= '0;
            dict3_write_val    <= '0;
        end else begin
            valid_q            <= valid_d;
            dict1_write_enable <= we1_d;
            dict2_write_enable <= we2_d;
            dict3_write_enable <= we3_d;
            done_q             <= done_d;
            if (accept && state == REQ1) dict1_write_val <= mem.rdata[FIELD1_VAL_WIDTH-1:0];
            if (accept && state == REQ2) dict2_write_val <= mem.rdata[FIELD2_VAL_WIDTH-1:0];
            if (accept && state == REQ3) dict3_write_val <= mem.rdata[FIELD3_VAL_WIDTH-1:0];
            if (state == WR1 || state == WR2 || state == WR3) begin
                idx    <= idx + IDX_W'(1);
                addr_q <= addr_q + 32'd4;
            end
        end
    end

`ifdef DICT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sum      <= '0;
            chk_seen <= 1'b0;
            chk_ok   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= err_d;
            if (accept && (state == REQ1 || state == REQ2 || state == REQ3)) begin
                sum <= sum + mem.rdata;
            end
            if (accept && state == CHK) begin
                chk_seen <= 1'b1;
                chk_ok   <= (mem.rdata == sum);
            end
        end
    end

    assign err = err_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^mem.rdata;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_dict_loader.sv
// Directed self-checking bench for dict_loader: zero-wait, wait-state, masking, mid-load reset,
// spurious-ready and (when DICT_LOADER_CHECKSUM_EN is defined) checksum-error loads.
module tb_dict_loader;

    localparam logic [31:0] BASE = 32'h000F_0000;
    localparam int          NT   = 296;
`ifdef DICT_LOADER_CHECKSUM_EN
    localparam int          CHK_ON = 1;
`else
    localparam int          CHK_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we1, we2, we3, done, err, proc_resetn;
    logic [6:0]  v1;
    logic [9:0]  v2;
    logic [14:0] v3;

    logic [31:0] image [0:NT];
    logic [31:0] widx;
    int          ws = 0;
    logic        spur = 1'b0;
    int          wcnt = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          n1 = 0, n2 = 0, n3 = 0, overlap = 0;
    bit          mon_en = 1'b0;
    bit          hold = 1'b0;
    logic [31:0] prev_addr = '0;

    always #5 clk = ~clk;

    dict_loader_if mem_if();

    dict_loader dut (
        .clk                (clk),
        .reset              (reset),
        .mem                (mem_if),
        .dict1_write_enable (we1),
        .dict1_write_val    (v1),
        .dict2_write_enable (we2),
        .dict2_write_val    (v2),
        .dict3_write_enable (we3),
        .dict3_write_val    (v3),
        .done               (done),
        .err                (err),
        .proc_resetn        (proc_resetn)
    );

    // Memory model: ready after ws waiting cycles, or forced high by spur regardless of valid.
    assign widx          = (mem_if.addr - BASE) >> 2;
    assign mem_if.rdata  = (widx <= 32'(NT)) ? image[widx[8:0]] : 32'hDEAD_BEEF;
    assign mem_if.ready  = (mem_if.valid && wcnt >= ws) || spur;

    always @(posedge clk) begin
        if (reset || !mem_if.valid || mem_if.ready) wcnt <= 0;
        else                                        wcnt <= wcnt + 1;
    end

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int expDone(input int w);
        return NT * (w + 2) + 1 + CHK_ON * (w + 2);
    endfunction

    task automatic fillImage(input bit masked, input bit corrupt);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < NT; i++) image[i] = 32'(i);
        if (masked) begin
            image[0]  = 32'hFFFF_FF85;
            image[8]  = 32'hABCD_E3FF;
            image[40] = 32'h1234_ABCD;
        end
        for (int i = 0; i < NT; i++) s = s + image[i];
        image[NT] = s + (corrupt ? 32'd1 : 32'd0);
    endtask

    task automatic applyStimulus(input int wait_states, input logic spurious);
        reset  = 1'b1;
        mon_en = 1'b0;
        ws     = wait_states;
        spur   = spurious;
        repeat (3) @(negedge clk);
        n1 = 0; n2 = 0; n3 = 0; overlap = 0; hold = 1'b0;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic waitFinish(output int at);
        int c;
        c = 0;
        while (!(done || err) && c < 4000) begin
            @(negedge clk);
            c++;
        end
        if (!(done || err)) checkOutput("finish_timeout", 32'd0, 32'd1);
        at = cyc;
    endtask

    task automatic checkLoad(input string tag);
        checkOutput({tag, "_n1"}, 32'(n1), 32'd8);
        checkOutput({tag, "_n2"}, 32'(n2), 32'd32);
        checkOutput({tag, "_n3"}, 32'(n3), 32'd256);
        checkOutput({tag, "_overlap"}, 32'(overlap), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_proc_resetn"}, 32'(proc_resetn), 32'd1);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 32'(mem_if.valid), 32'd0);
        checkOutput({tag, "_addr"}, mem_if.addr, BASE);
        checkOutput({tag, "_we"}, {29'd0, we1, we2, we3}, 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_proc_resetn"}, 32'(proc_resetn), 32'd0);
        checkOutput({tag, "_vals"}, {v1, v2, v3}, 32'd0);
    endtask

    // Scoreboard: strobe values in order, request address, and request stability while waiting.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && mon_en) begin
                if (int'(we1) + int'(we2) + int'(we3) > 1) overlap++;
                if (hold) begin
                    checkOutput("hold_valid", 32'(mem_if.valid), 32'd1);
                    checkOutput("hold_addr", mem_if.addr, prev_addr);
                end
                if (mem_if.valid && mem_if.ready)
                    checkOutput("req_addr", mem_if.addr, BASE + 32'(4 * (n1 + n2 + n3)));
                if (we1) begin
                    if (n1 < 8) checkOutput("d1_val", 32'(v1), 32'(image[n1][6:0]));
                    n1++;
                end
                if (we2) begin
                    if (n2 < 32) checkOutput("d2_val", 32'(v2), 32'(image[8 + n2][9:0]));
                    n2++;
                end
                if (we3) begin
                    if (n3 < 256) checkOutput("d3_val", 32'(v3), 32'(image[40 + n3][14:0]));
                    n3++;
                end
                hold      = mem_if.valid && !mem_if.ready;
                prev_addr = mem_if.addr;
            end
        end
    end

    initial begin
        int at;
        int c;
        fillImage(1'b0, 1'b0);

        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkResetState("rst");

        applyStimulus(0, 1'b0);
        @(negedge clk);
        checkOutput("first_valid", 32'(mem_if.valid), 32'd1);
        checkOutput("first_addr", mem_if.addr, BASE);
        waitFinish(at);
        checkOutput("zw_done_cycle", 32'(at), 32'(expDone(0)));
        checkLoad("zw");

        applyStimulus(3, 1'b0);
        waitFinish(at);
        checkOutput("ws3_done_cycle", 32'(at), 32'(expDone(3)));
        checkLoad("ws3");

        fillImage(1'b1, 1'b0);
        applyStimulus(0, 1'b0);
        c = 0;
        while (!we1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        checkOutput("mask_w0", 32'(v1), 32'h05);
        waitFinish(at);
        checkLoad("mask");

        fillImage(1'b0, 1'b0);
        applyStimulus(0, 1'b0);
        c = 0;
        while (!(we2 && v2 == 10'd28) && c < 500) begin
            @(negedge clk);
            c++;
        end
        checkOutput("mid_found_wr2", 32'(we2), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkResetState("mid_rst");
        applyStimulus(0, 1'b0);
        @(negedge clk);
        checkOutput("mid_restart_addr", mem_if.addr, BASE);
        c = 0;
        while (!(we1 || we2 || we3) && c < 50) begin
            @(negedge clk);
            c++;
        end
        checkOutput("mid_first_we1", {29'd0, we1, we2, we3}, 32'b100);
        checkOutput("mid_first_val", 32'(v1), 32'd0);
        waitFinish(at);
        checkLoad("mid");

        applyStimulus(0, 1'b1);
        waitFinish(at);
        checkOutput("spur_done_cycle", 32'(at), 32'(expDone(0)));
        checkLoad("spur");
        repeat (20) @(negedge clk);
        checkOutput("spur_total", 32'(n1 + n2 + n3), 32'd296);
        checkOutput("spur_idx_addr", mem_if.addr, BASE + 32'd1184);
        checkOutput("spur_done_hold", 32'(done), 32'd1);
        spur = 1'b0;

`ifdef DICT_LOADER_CHECKSUM_EN
        fillImage(1'b0, 1'b1);
        applyStimulus(0, 1'b0);
        waitFinish(at);
        checkOutput("cks_err_cycle", 32'(at), 32'(expDone(0)));
        checkOutput("cks_err", 32'(err), 32'd1);
        checkOutput("cks_done", 32'(done), 32'd0);
        checkOutput("cks_proc_resetn", 32'(proc_resetn), 32'd0);
        repeat (100) @(negedge clk);
        checkOutput("cks_err_hold", 32'(err), 32'd1);
        checkOutput("cks_done_hold", 32'(done), 32'd0);
        checkOutput("cks_proc_hold", 32'(proc_resetn), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
